blk_fifo_ctrl: RTL and testbench
================================

// Module: blk_fifo_ctrl
// PURPOSE
//  Sequencer for the byte-in / 512-bit-out block FIFO. Accepts a valid/ready
//  byte stream and forwards it as FIFO writes with backpressure. Pops one
//  64-byte block when the FIFO reports >=64 bytes and presents it downstream
//  on a valid/ready block interface. Also generates the FIFO's synchronous
//  active-high reset. Sits between the byte source and the block consumer.
// PARAMETERS
//  FULL_LIMIT  255  byte count at/above which o_byte_ready drops (max 255)
//  RST_HOLD    2    cycles the FIFO reset stays high after i_rst_n releases
//  BLK_BYTES   64   bytes per block; must match the FIFO pop size
// PORTS
//  i_clk          in   1    clock
//  i_rst_n        in   1    asynchronous active-low reset
//  i_byte_valid   in   1    source byte valid
//  i_byte         in   8    source byte
//  o_byte_ready   out  1    byte accepted when valid&ready
//  o_fifo_rst     out  1    to FIFO i_rst (sync, active-high)
//  o_fifo_wr_en   out  1    to FIFO i_wr_en
//  o_fifo_data    out  8    to FIFO i_data
//  o_fifo_rd_en   out  1    to FIFO i_rd_en
//  i_fifo_data    in   512  from FIFO o_data (valid 1 cycle after rd_en)
//  i_fifo_cnt     in   8    from FIFO o_data_cnt
//  o_blk_valid    out  1    block valid; held until i_blk_ready
//  o_blk_data     out  512  block payload, stable while o_blk_valid
//  i_blk_ready    in   1    consumer ready
//  o_blk_idx      out  16   index of presented block since reset, wraps
// BEHAVIOUR
//  Reset (i_rst_n low): o_fifo_rst=1, o_blk_valid=0, o_blk_data=0,
//   o_blk_idx=0, o_fifo_rd_en=0, state=RST. After release o_fifo_rst stays 1
//   for RST_HOLD rising edges, then 0 and state->IDLE. Reset mid-block drops
//   the block; no partial delivery.
//  Byte path (combinational): o_byte_ready = (state!=RST) &&
//   (i_fifo_cnt < FULL_LIMIT); o_fifo_wr_en = i_byte_valid & o_byte_ready;
//   o_fifo_data = i_byte. FIFO never exceeds 255, so no overwrite/wrap of
//   unread data. Writes continue in every non-RST state, incl. the pop cycle.
//  FSM (registered, o_fifo_rd_en is a registered 1-cycle pulse):
//   RST  -> IDLE after RST_HOLD cycles.
//   IDLE -> POP when i_fifo_cnt >= BLK_BYTES; drive o_fifo_rd_en=1 next cycle.
//   POP  : rd_en high this cycle (exactly one cycle) -> CAP.
//   CAP  : FIFO output now valid; latch i_fifo_data into o_blk_data,
//          set o_blk_valid=1 -> HOLD.
//   HOLD : when i_blk_ready: o_blk_valid=0, o_blk_idx+=1 -> IDLE.
//  Pop-to-valid latency: 3 cycles from cnt>=64 seen in IDLE to o_blk_valid.
//  Only one block in flight; next pop not issued until handshake completes.
//  Simultaneous write+pop: FIFO count nets -63; controller takes no action.
//  Byte ordering inside o_blk_data is the FIFO's (32-bit word byte-swapped);
//   passed through unmodified.
//  o_blk_idx is 16-bit, wraps 0xFFFF->0; increments on handshake only.
//  Count sampled in IDLE only; a stale count in POP/CAP/HOLD is ignored.
// STRUCTURE
//  Shared package blk_fifo_pkg: state enum {RST,IDLE,POP,CAP,HOLD},
//   BLK_BYTES, BLK_W=512, CNT_W=8.
//  One sub-module natural: blk_fifo_rst_gen (async-assert/sync-release
//   counter producing o_fifo_rst). Top instantiates it plus the FIFO-facing
//   FSM; bench instantiates blk_fifo_ctrl with the real FIFO.
// TESTING
//  1 Reset: pulse i_rst_n low 3 cyc -> o_fifo_rst high until 2 edges after
//    release, o_blk_valid=0, o_byte_ready=0 during RST.
//  2 Single block: stream bytes 0x00..0x3F, i_blk_ready=1 -> exactly one
//    rd_en pulse, o_blk_data[511:480]=0x3C3D3E3F, [31:0]=0x00010203, idx 0->1.
//  3 Backpressure downstream: 128 bytes, i_blk_ready=0 for 20 cyc -> valid
//    and data stable, one rd_en only; after ready second block delivered, idx=2.
//  4 Full: source always valid, consumer never ready -> cnt peaks 255 minus
//    popped 64 path; o_byte_ready=0 at cnt=255, no byte lost or duplicated.
//  5 Concurrent write during POP: byte written in rd_en cycle -> FIFO cnt
//    goes 64->1, byte appears as first byte of next block.
//  6 Reset in HOLD: assert i_rst_n low while o_blk_valid=1 -> valid drops
//    asynchronously, idx=0, FIFO cleared, next block starts from fresh bytes.

Source files
------------

// File: rtl/blk_fifo_pkg.sv
// Shared sizes and state type for the byte-in / block-out FIFO sequencer.
package blk_fifo_pkg;

    localparam int BLK_BYTES = 64;
    localparam int BLK_W     = 512;
    localparam int CNT_W     = 8;
    localparam int IDX_W     = 16;

    typedef enum logic [2:0] {
        ST_RST,
        ST_IDLE,
        ST_POP,
        ST_CAP,
        ST_HOLD
    } blkState_e;

endpackage

// File: rtl/blk_fifo_rst_gen.sv
// FIFO reset generator: asserts with i_rst_n, releases RST_HOLD edges later.
// RST_HOLD must be in 1..256 so the hold counter fits in 8 bits.
module blk_fifo_rst_gen #(
    parameter int RST_HOLD = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_fifo_rst,
    output logic o_release
);

    localparam logic [7:0] LAST_CNT = 8'(RST_HOLD - 1);

    logic [7:0] holdCnt_q;
    logic [7:0] holdCnt_d;
    logic       fifoRst_q;
    logic       fifoRst_d;

    // Count edges while the FIFO reset is held; drop it on the last one.
    always_comb begin
        holdCnt_d = holdCnt_q;
        fifoRst_d = fifoRst_q;
        if (fifoRst_q) begin
            if (holdCnt_q == LAST_CNT) begin
                fifoRst_d = 1'b0;
            end else begin
                holdCnt_d = holdCnt_q + 8'd1;
            end
        end
    end

    // Asynchronous assertion, release only ever happens on a clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            holdCnt_q <= 8'd0;
            fifoRst_q <= 1'b1;
        end else begin
            holdCnt_q <= holdCnt_d;
            fifoRst_q <= fifoRst_d;
        end
    end

    assign o_fifo_rst = fifoRst_q;
    assign o_release  = fifoRst_q && (holdCnt_q == LAST_CNT);

endmodule

// File: rtl/blk_fifo_ctrl.sv
// Block FIFO sequencer: forwards a byte stream into the FIFO and pops one
// 64-byte block at a time onto a valid/ready block interface.
module blk_fifo_ctrl
    import blk_fifo_pkg::*;
#(
    parameter int FULL_LIMIT = 255,
    parameter int RST_HOLD   = 2
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_byte_valid,
    input  logic [7:0]          i_byte,
    output logic                o_byte_ready,
    output logic                o_fifo_rst,
    output logic                o_fifo_wr_en,
    output logic [7:0]          o_fifo_data,
    output logic                o_fifo_rd_en,
    input  logic [BLK_W-1:0]    i_fifo_data,
    input  logic [CNT_W-1:0]    i_fifo_cnt,
    output logic                o_blk_valid,
    output logic [BLK_W-1:0]    o_blk_data,
    input  logic                i_blk_ready,
    output logic [IDX_W-1:0]    o_blk_idx
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FULL_LIMIT);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLK_BYTES);

    blkState_e          state_q;
    logic               fifoRdEn_q;
    logic               blkValid_q;
    logic [BLK_W-1:0]   blkData_q;
    logic [IDX_W-1:0]   blkIdx_q;
    logic               rstRelease;

    blk_fifo_rst_gen #(
        .RST_HOLD   (RST_HOLD)
    ) u_rst_gen (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .o_fifo_rst (o_fifo_rst),
        .o_release  (rstRelease)
    );

    assign o_byte_ready = (state_q != ST_RST) && (i_fifo_cnt < FULL_CNT);
    assign o_fifo_wr_en = i_byte_valid && o_byte_ready;
    assign o_fifo_data  = i_byte;

    // Pop, capture and hold one block; the count is only looked at in IDLE.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_RST;
            fifoRdEn_q <= 1'b0;
            blkValid_q <= 1'b0;
            blkData_q  <= '0;
            blkIdx_q   <= '0;
        end else begin
            fifoRdEn_q <= 1'b0;
            case (state_q)
                ST_RST: begin
                    if (rstRelease) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (i_fifo_cnt >= BLK_CNT) begin
                        fifoRdEn_q <= 1'b1;
                        state_q    <= ST_POP;
                    end
                end
                ST_POP: begin
                    state_q <= ST_CAP;
                end
                ST_CAP: begin
                    blkData_q  <= i_fifo_data;
                    blkValid_q <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (i_blk_ready) begin
                        blkValid_q <= 1'b0;
                        blkIdx_q   <= blkIdx_q + 16'd1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase
        end
    end

    assign o_fifo_rd_en = fifoRdEn_q;
    assign o_blk_valid  = blkValid_q;
    assign o_blk_data   = blkData_q;
    assign o_blk_idx    = blkIdx_q;

endmodule

// File: tb/tb_blk_fifo_ctrl.sv
// Testbench for blk_fifo_ctrl with a behavioural byte-in / block-out FIFO.
module tb_blk_fifo_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         byteValid = 1'b0;
    logic [7:0]   byteIn = 8'd0;
    logic         blkReady = 1'b0;

    logic         byteReady;
    logic         fifoRst;
    logic         fifoWrEn;
    logic [7:0]   fifoWrData;
    logic         fifoRdEn;
    logic         blkValid;
    logic [511:0] blkData;
    logic [15:0]  blkIdx;

    logic [7:0]   fifoCnt = 8'd0;
    logic [511:0] fifoOut = '0;
    logic [511:0] popBlk;
    logic [7:0]   fifoMem[$];
    int           fifoErrors = 0;

    logic         cntOverride = 1'b0;
    logic [7:0]   overrideCnt = 8'd0;
    logic [7:0]   cntToDut;

    int           checkCount = 0;
    int           passCount = 0;

    logic [7:0]   streamQ[$];
    bit           monOn = 1'b0;
    int           expIdx = 0;
    int           blocksSeen = 0;
    int           rdPulses = 0;
    int           cycleNo = 0;
    int           cntHitCycle = -1;
    int           rdEnCycle = -1;
    int           validCycle = -1;
    logic [511:0] lastBlk = '0;
    logic [511:0] expBlk;
    logic         prevRdEn = 1'b0;
    logic         prevValid = 1'b0;
    logic         prevReady = 1'b0;
    logic [511:0] prevData = '0;
    logic [15:0]  prevIdx = '0;

    typedef struct packed {
        logic [7:0] cnt;
        logic       valid;
        logic [7:0] data;
        logic       expReady;
        logic       expWr;
    } vec_t;

    localparam int NVEC = 8;
    vec_t vecs[NVEC];

    assign cntToDut = cntOverride ? overrideCnt : fifoCnt;

    always #5 clk = ~clk;

    blk_fifo_ctrl dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_byte_valid (byteValid),
        .i_byte       (byteIn),
        .o_byte_ready (byteReady),
        .o_fifo_rst   (fifoRst),
        .o_fifo_wr_en (fifoWrEn),
        .o_fifo_data  (fifoWrData),
        .o_fifo_rd_en (fifoRdEn),
        .i_fifo_data  (fifoOut),
        .i_fifo_cnt   (cntToDut),
        .o_blk_valid  (blkValid),
        .o_blk_data   (blkData),
        .i_blk_ready  (blkReady),
        .o_blk_idx    (blkIdx)
    );

    // Behavioural FIFO: a pop moves 64 bytes out (big-endian within each
    // 32-bit word) before a same-cycle write is appended.
    always @(posedge clk) begin
        if (fifoRst) begin
            fifoMem.delete();
            fifoOut <= '0;
            fifoCnt <= 8'd0;
        end else begin
            if (fifoRdEn) begin
                popBlk = '0;
                for (int j = 0; j < 64; j++) begin
                    if (fifoMem.size() > 0) begin
                        popBlk[32*(j/4) + 8*(3-(j%4)) +: 8] = fifoMem.pop_front();
                    end else begin
                        fifoErrors++;
                    end
                end
                fifoOut <= popBlk;
            end
            if (fifoWrEn) begin
                fifoMem.push_back(fifoWrData);
            end
            if (fifoMem.size() > 255) begin
                fifoErrors++;
            end
            fifoCnt <= 8'(fifoMem.size());
        end
    end

    task automatic checkOutput(input string name, input logic [511:0] actual,
                               input logic [511:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 512'(actual), 512'(expected));
    endtask

    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
        byteValid = valid;
        byteIn    = data;
        blkReady  = ready;
    endtask

    // Stream-level scoreboard: every accepted byte is queued, every handshake
    // must deliver the next 64 of them with the next block index.
    always @(negedge clk) begin
        cycleNo++;
        if (monOn && rst_n) begin
            checkBit("byte_ready", byteReady, fifoCnt < 8'd255);
            checkBit("fifo_wr_en", fifoWrEn, byteValid && (fifoCnt < 8'd255));
            if (fifoWrEn) begin
                checkOutput("fifo_data", 512'(fifoWrData), 512'(byteIn));
            end
            if (byteValid && byteReady) begin
                streamQ.push_back(byteIn);
            end
            if (fifoCnt >= 8'd64 && cntHitCycle < 0) begin
                cntHitCycle = cycleNo;
            end
            if (fifoRdEn) begin
                rdPulses++;
                if (rdEnCycle < 0) rdEnCycle = cycleNo;
                checkBit("rd_en_single_pulse", prevRdEn, 1'b0);
                checkBit("rd_en_while_valid", blkValid, 1'b0);
            end
            if (blkValid) begin
                if (validCycle < 0) validCycle = cycleNo;
                if (prevValid && !prevReady) begin
                    checkOutput("blk_data_stable", blkData, prevData);
                    checkOutput("blk_idx_stable", 512'(blkIdx), 512'(prevIdx));
                end
                if (blkReady) begin
                    checkBit("stream_has_block", streamQ.size() >= 64, 1'b1);
                    expBlk = '0;
                    for (int j = 0; j < 64 && streamQ.size() > 0; j++) begin
                        expBlk[32*(j/4) + 8*(3-(j%4)) +: 8] = streamQ.pop_front();
                    end
                    checkOutput("blk_data", blkData, expBlk);
                    checkOutput("blk_idx", 512'(blkIdx), 512'(16'(expIdx)));
                    expIdx++;
                    lastBlk = blkData;
                    blocksSeen++;
                end
            end
        end
        prevRdEn  = fifoRdEn;
        prevValid = blkValid;
        prevReady = blkReady;
        prevData  = blkData;
        prevIdx   = blkIdx;
    end

    task automatic applyReset();
        monOn = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'd0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkBit("rst_async_valid", blkValid, 1'b0);
        checkOutput("rst_async_idx", 512'(blkIdx), 512'(0));
        checkOutput("rst_async_data", blkData, 512'(0));
        checkBit("rst_async_fifo_rst", fifoRst, 1'b1);
        repeat (3) begin
            @(negedge clk);
            checkBit("rst_fifo_rst", fifoRst, 1'b1);
            checkBit("rst_byte_ready", byteReady, 1'b0);
            checkBit("rst_rd_en", fifoRdEn, 1'b0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checkBit("rel_edge0_fifo_rst", fifoRst, 1'b1);
        @(negedge clk);
        checkBit("rel_edge1_fifo_rst", fifoRst, 1'b1);
        checkBit("rel_edge1_ready", byteReady, 1'b0);
        @(negedge clk);
        checkBit("rel_edge2_fifo_rst", fifoRst, 1'b0);
        checkBit("rel_edge2_ready", byteReady, 1'b1);
        checkOutput("rel_fifo_empty", 512'(fifoCnt), 512'(0));
        checkOutput("rel_idx", 512'(blkIdx), 512'(0));
        streamQ.delete();
        expIdx = 0;
        monOn  = 1'b1;
    endtask

    task automatic sendBytes(input int n, input logic [7:0] first, input bit randomData,
                             input logic ready);
        int sent = 0;
        int budget = 0;
        logic [7:0] val = first;
        while (sent < n && budget < 4*n + 200) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, val, ready);
            @(negedge clk);
            if (byteReady) begin
                sent++;
                val = randomData ? 8'($urandom) : val + 8'd1;
            end
            budget++;
        end
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'd0, ready);
        checkOutput("send_bytes", 512'(sent), 512'(n));
    endtask

    task automatic waitBlocks(input int target, input int budget);
        for (int i = 0; i < budget && blocksSeen < target; i++) begin
            @(negedge clk);
        end
        checkOutput("wait_blocks", 512'(blocksSeen), 512'(target));
        @(posedge clk); #1;
    endtask

    task automatic drainQuiet();
        int quiet = 0;
        applyStimulus(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < 300 && quiet < 4; i++) begin
            @(negedge clk);
            quiet = (!blkValid && !fifoRdEn && fifoCnt < 8'd64) ? quiet + 1 : 0;
        end
        checkBit("drain_quiet", quiet >= 4, 1'b1);
        checkOutput("stream_vs_fifo", 512'(streamQ.size()), 512'(fifoCnt));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int startBlocks;
        int maxCnt;
        logic [7:0] val4;
        bit holding;

        vecs[0] = '{cnt: 8'd0,   valid: 1'b1, data: 8'h11, expReady: 1'b1, expWr: 1'b1};
        vecs[1] = '{cnt: 8'd63,  valid: 1'b1, data: 8'h22, expReady: 1'b1, expWr: 1'b1};
        vecs[2] = '{cnt: 8'd64,  valid: 1'b0, data: 8'h33, expReady: 1'b1, expWr: 1'b0};
        vecs[3] = '{cnt: 8'd200, valid: 1'b1, data: 8'h44, expReady: 1'b1, expWr: 1'b1};
        vecs[4] = '{cnt: 8'd254, valid: 1'b1, data: 8'h55, expReady: 1'b1, expWr: 1'b1};
        vecs[5] = '{cnt: 8'd255, valid: 1'b1, data: 8'h66, expReady: 1'b0, expWr: 1'b0};
        vecs[6] = '{cnt: 8'd255, valid: 1'b0, data: 8'h77, expReady: 1'b0, expWr: 1'b0};
        vecs[7] = '{cnt: 8'd128, valid: 1'b1, data: 8'h88, expReady: 1'b1, expWr: 1'b1};

        $display("[TB] test 1: reset sequence");
        applyReset();

        $display("[TB] byte path vector table");
        monOn = 1'b0;
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            cntOverride = 1'b1;
            overrideCnt = vecs[i].cnt;
            applyStimulus(vecs[i].valid, vecs[i].data, 1'b0);
            #2;
            checkBit("tbl_ready", byteReady, vecs[i].expReady);
            checkBit("tbl_wr_en", fifoWrEn, vecs[i].expWr);
            checkOutput("tbl_data", 512'(fifoWrData), 512'(vecs[i].data));
            #2;
            cntOverride = 1'b0;
            applyStimulus(1'b0, 8'd0, 1'b0);
        end
        monOn = 1'b1;

        $display("[TB] test 2: single block");
        rdPulses = 0;
        cntHitCycle = -1;
        rdEnCycle = -1;
        validCycle = -1;
        startBlocks = blocksSeen;
        sendBytes(64, 8'h00, 1'b0, 1'b1);
        waitBlocks(startBlocks + 1, 40);
        repeat (3) @(negedge clk);
        checkOutput("t2_rd_pulses", 512'(rdPulses), 512'(1));
        checkOutput("t2_top_word", 512'(lastBlk[511:480]), 512'(32'h3C3D3E3F));
        checkOutput("t2_low_word", 512'(lastBlk[31:0]), 512'(32'h00010203));
        checkOutput("t2_idx", 512'(blkIdx), 512'(1));
        checkOutput("t2_rd_latency", 512'(rdEnCycle - cntHitCycle), 512'(1));
        checkOutput("t2_valid_latency", 512'(validCycle - cntHitCycle), 512'(3));

        $display("[TB] test 3: downstream backpressure");
        applyReset();
        rdPulses = 0;
        startBlocks = blocksSeen;
        sendBytes(128, 8'h10, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checkBit("t3_valid_held", blkValid, 1'b1);
        checkOutput("t3_rd_pulses_hold", 512'(rdPulses), 512'(1));
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'd0, 1'b1);
        waitBlocks(startBlocks + 2, 40);
        @(negedge clk);
        checkOutput("t3_idx", 512'(blkIdx), 512'(2));
        checkOutput("t3_rd_pulses", 512'(rdPulses), 512'(2));

        $display("[TB] test 5: write during pop cycle");
        startBlocks = blocksSeen;
        sendBytes(64, 8'h80, 1'b0, 1'b1);
        holding = 1'b0;
        for (int i = 0; i < 20 && !holding; i++) begin
            if (fifoRdEn) begin
                holding = 1'b1;
                applyStimulus(1'b1, 8'hA5, 1'b1);
                @(negedge clk);
                checkBit("t5_pop_write_ready", byteReady, 1'b1);
                @(posedge clk); #1;
                applyStimulus(1'b0, 8'd0, 1'b1);
                checkOutput("t5_cnt_after", 512'(fifoCnt), 512'(1));
            end else begin
                @(posedge clk); #1;
            end
        end
        checkBit("t5_saw_rd_en", holding, 1'b1);
        sendBytes(63, 8'h40, 1'b0, 1'b1);
        waitBlocks(startBlocks + 2, 60);
        checkOutput("t5_first_byte", 512'(lastBlk[31:24]), 512'(8'hA5));
        checkOutput("t5_second_byte", 512'(lastBlk[23:16]), 512'(8'h40));

        $display("[TB] test 4: full FIFO");
        rdPulses = 0;
        maxCnt = 0;
        val4 = 8'd0;
        startBlocks = blocksSeen;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            applyStimulus(1'b1, val4, 1'b0);
            @(negedge clk);
            if (int'(fifoCnt) > maxCnt) maxCnt = int'(fifoCnt);
            if (byteReady) val4 = val4 + 8'd1;
        end
        checkOutput("t4_peak_cnt", 512'(maxCnt), 512'(255));
        checkBit("t4_ready_at_full", byteReady, 1'b0);
        checkOutput("t4_accepted", 512'(streamQ.size()), 512'(319));
        checkOutput("t4_rd_pulses", 512'(rdPulses), 512'(1));
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'd0, 1'b1);
        waitBlocks(startBlocks + 4, 120);
        repeat (4) @(negedge clk);
        checkOutput("t4_residual", 512'(fifoCnt), 512'(63));

        $display("[TB] random traffic");
        holding = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            if (!holding) begin
                byteValid = ($urandom_range(0, 9) < 7);
                byteIn    = 8'($urandom);
            end
            blkReady = 1'($urandom_range(0, 1));
            @(negedge clk);
            holding = byteValid && !byteReady;
        end
        @(posedge clk); #1;
        drainQuiet();

        $display("[TB] test 6: reset while block held");
        sendBytes(64, 8'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 20 && !blkValid; i++) @(negedge clk);
        checkBit("t6_valid_before_reset", blkValid, 1'b1);
        applyReset();
        startBlocks = blocksSeen;
        sendBytes(64, 8'hC0, 1'b0, 1'b1);
        waitBlocks(startBlocks + 1, 40);
        @(negedge clk);
        checkOutput("t6_fresh_first", 512'(lastBlk[31:24]), 512'(8'hC0));
        checkOutput("t6_fresh_byte60", 512'(lastBlk[511:504]), 512'(8'hFC));
        checkOutput("t6_idx", 512'(blkIdx), 512'(1));
        drainQuiet();

        monOn = 1'b0;
        checkOutput("fifo_model_errors", 512'(fifoErrors), 512'(0));
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
